adder_seq_chunked: RTL and testbench

- Parametrised multi-cycle adder. Successor to the fixed 32-bit combinational ripple adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, LSB chunk first.
- Uses a start/busy/done handshake and holds the result until the next operation.
- Used where a full-width carry chain would break timing, and as the arithmetic core for later sequential datapath assignments (multiplier, accumulator).

---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_chunk.sv | 29 ++
 rtl/adder_seq_chunked.sv | 144 ++++++++++++++
 tb/tb_adder_seq_chunked.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the chunked sequential adder.
//   - S_IDLE / S_BUSY / S_DONE : FSM state encoding
//   - signed_ovf()             : two's-complement overflow from the sign bits
package adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Overflow happens when both operands share a sign and the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: purely combinational CHUNK-bit ripple-carry adder.
// Ports:
//   sum  [CHUNK-1:0] out : a + b + cin (low CHUNK bits)
//   cout             out : carry out of bit CHUNK-1
//   a, b [CHUNK-1:0] in  : operand chunks
//   cin              in  : carry into bit 0
module adder_chunk #(
  parameter int CHUNK = 8
) (
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_seq_chunked.sv
// adder_seq_chunked: multi-cycle WIDTH-bit adder, CHUNK bits per clock,
// LSB chunk first, with a start/busy/done handshake. The result is held
// until the next accepted start or rst.
// Optional feature (macro ADDER_SUB_EN): adds input `sub`; when set at
// start, computes a - b (B inverted, initial carry forced to 1).
// Ports:
//   clk, rst (sync, active-high)
//   start           : request new operation (accepted in IDLE or DONE)
//   a, b [WIDTH]    : operands, sampled with start
//   cin             : carry-in, sampled with start
//   sub             : (ADDER_SUB_EN only) subtract select, sampled with start
//   sum [WIDTH]     : result, valid while done
//   carry, overflow : carry-out / signed overflow, valid while done
//   busy, done      : handshake status
module adder_seq_chunked
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Operands and result are viewed as arrays of chunks so the active
  // chunk is selected directly by the chunk index.
  logic [1:0]                         state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NCHUNK-1:0][CHUNK-1:0]       a_q, a_d;
  logic [NCHUNK-1:0][CHUNK-1:0]       b_q, b_d;
  logic                               crun_q, crun_d;
  logic [NCHUNK-1:0][CHUNK-1:0]       sum_q, sum_d;
  logic                               carry_q, carry_d;
  logic                               ovf_q, ovf_d;

  logic [CHUNK-1:0]                   chunk_sum;
  logic                               chunk_cout;
  logic                               accept;

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (crun_q)
  );

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // State register plus control/result registers; operand latches carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      crun_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      crun_q  <= crun_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_BUSY;
      S_BUSY:         if (idx_q == LAST_IDX) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    crun_d  = crun_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = a;
`ifdef ADDER_SUB_EN
      b_d     = sub ? ~b : b;
      crun_d  = sub ? 1'b1 : cin;
`else
      b_d     = b;
      crun_d  = cin;
`endif
      idx_d   = '0;
      sum_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == S_BUSY) begin
      sum_d[idx_q] = chunk_sum;
      crun_d       = chunk_cout;
      idx_d        = idx_q + 1'b1;
      // The last chunk holds the sign bits of both operands and the result.
      if (idx_q == LAST_IDX) begin
        carry_d = chunk_cout;
        ovf_d   = signed_ovf(a_q[NCHUNK-1][CHUNK-1], b_q[NCHUNK-1][CHUNK-1],
                             chunk_sum[CHUNK-1]);
      end
    end
  end

  // Output logic
  always_comb begin
    busy     = (state_q == S_BUSY);
    done     = (state_q == S_DONE);
    sum      = sum_q;
    carry    = carry_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_adder_seq_chunked.sv
// tb_adder_seq_chunked: directed and randomized bench for adder_seq_chunked
// (WIDTH=32, CHUNK=8). Expected results come from plain wide arithmetic.
// Build with +define+ADDER_SUB_EN to also cover the subtract option.
module tb_adder_seq_chunked;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             sub_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             ovf_o;
  logic             busy_o;
  logic             done_o;

  int n_checks;
  int n_pass;
  int n_fail;

  adder_seq_chunked #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a_i),
    .b        (b_i),
    .cin      (cin_i),
`ifdef ADDER_SUB_EN
    .sub      (sub_i),
`endif
    .sum      (sum_o),
    .carry    (carry_o),
    .overflow (ovf_o),
    .busy     (busy_o),
    .done     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " sum"},      64'(sum_o),   64'd0);
    check({tag, " carry"},    64'(carry_o), 64'd0);
    check({tag, " overflow"}, 64'(ovf_o),   64'd0);
    check({tag, " busy"},     64'(busy_o),  64'd0);
    check({tag, " done"},     64'(done_o),  64'd0);
  endtask

  // Reference: a + B + c with B/c chosen by the subtract option.
  task automatic model(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                       input logic ts, output logic [31:0] es, output logic ec,
                       output logic eo);
    logic [31:0] bb;
    logic        cc;
    logic [32:0] wide;
    longint      ss;
    bb   = ts ? ~tb_v : tb_v;
    cc   = ts ? 1'b1 : tc;
    wide = {1'b0, ta} + {1'b0, bb} + {32'd0, cc};
    es   = wide[31:0];
    ec   = wide[32];
    ss   = longint'($signed(ta)) + longint'($signed(bb)) + longint'(cc);
    eo   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
  endtask

  // Wait for done, bounded; returns edges counted since the start edge.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (done_o !== 1'b1 && cycles < 4 * NCHUNK + 8) begin
      @(posedge clk); #1;
      cycles++;
      if (busy_o === 1'b1) busy_cnt++;
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                        input logic ts, input string tag);
    logic [31:0] es;
    logic        ec, eo;
    int          cyc, bcnt;
    model(ta, tb_v, tc, ts, es, ec, eo);
    @(negedge clk);
    a_i = ta; b_i = tb_v; cin_i = tc; sub_i = ts; start = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy after start"}, 64'(busy_o), 64'd1);
    check({tag, " done after start"}, 64'(done_o), 64'd0);
    @(negedge clk);
    start = 1'b0;
    // Latched copies only: scramble the live inputs.
    a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom); sub_i = 1'($urandom);
    wait_done(cyc, bcnt);
    check({tag, " latency"},    64'(cyc),      64'(NCHUNK));
    check({tag, " busy cycles"}, 64'(bcnt + 1), 64'(NCHUNK));
    check({tag, " sum"},        64'(sum_o),    64'(es));
    check({tag, " carry"},      64'(carry_o),  64'(ec));
    check({tag, " overflow"},   64'(ovf_o),    64'(eo));
    check({tag, " busy at done"}, 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    check({tag, " hold done"},  64'(done_o),   64'd1);
    check({tag, " hold sum"},   64'(sum_o),    64'(es));
  endtask

  initial begin
    int cyc, bcnt;
    logic [31:0] ra, rb;
    logic        rc;
    n_checks = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_idle("reset");

    // Carry ripple across chunks, wrap, signed overflow
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, "ripple");
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, "wrap");
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "ovf_pos");
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, "ovf_neg");

    // Start while busy is ignored
    @(negedge clk); a_i = 32'd5; b_i = 32'd6; cin_i = 1'b0; sub_i = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); a_i = 32'd100; b_i = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    check("ignore busy still busy", 64'(busy_o), 64'd1);
    @(negedge clk); start = 1'b0;
    wait_done(cyc, bcnt);
    check("ignore sum", 64'(sum_o), 64'd11);
    check("ignore latency", 64'(cyc + 2), 64'(NCHUNK));

    // Back-to-back start from DONE: done falls on the accepting edge
    @(negedge clk); a_i = 32'd40; b_i = 32'd2; cin_i = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("b2b done drop", 64'(done_o), 64'd0);
    check("b2b busy",      64'(busy_o), 64'd1);
    @(negedge clk); start = 1'b0;
    wait_done(cyc, bcnt);
    check("b2b sum", 64'(sum_o), 64'd43);

    // Reset mid-operation
    @(negedge clk); a_i = 32'h12345678; b_i = 32'd1; cin_i = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_idle("mid reset");
    @(negedge clk); rst = 1'b0;
    repeat (NCHUNK + 2) @(posedge clk);
    #1;
    check("mid reset stays idle", 64'(done_o), 64'd0);
    run_op(32'd2, 32'd3, 1'b0, 1'b0, "after reset");

`ifdef ADDER_SUB_EN
    run_op(32'd10, 32'd3,  1'b0, 1'b1, "sub pos");
    run_op(32'd3,  32'd10, 1'b1, 1'b1, "sub neg");
    run_op(32'h80000000, 32'd1, 1'b0, 1'b1, "sub ovf");
`endif

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      if (i % 6 == 0) rb = ~ra;
`ifdef ADDER_SUB_EN
      run_op(ra, rb, rc, 1'($urandom), $sformatf("rand%0d", i));
`else
      run_op(ra, rb, rc, 1'b0, $sformatf("rand%0d", i));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
